// File: rtl/button_event_scheduler.sv
// button_event_scheduler
// Turns four debounced button levels into discrete PRESS / RELEASE / LONG /
// REPEAT events. A round-robin arbiter feeds a small first-word-fall-through
// FIFO, and the consumer drains it over a valid/ready handshake.
// Build option: define BUTTON_AUTO_REPEAT_EN to emit REPEAT events while a
// button stays held after LONG. Without it the hold counter saturates in LONG
// and REPEAT (code 3) is never produced.

module button_event_scheduler #(
  parameter int TICK_DIV     = 50000,
  parameter int LONG_TICKS   = 40,
  parameter int REPEAT_TICKS = 10,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] button_in,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [1:0] evt_code,
  output logic [1:0] evt_id,
  output logic       evt_lost,
  input  logic       evt_lost_clr
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [7:0]       LONG_LIM  = 8'(LONG_TICKS);
  localparam logic [CW-1:0]    FULL_CNT  = CW'(FIFO_DEPTH);

  // A configuration outside the legal ranges freezes the hold timers instead
  // of producing meaningless LONG/REPEAT timing.
  localparam bit CFG_OK = (LONG_TICKS >= 1) && (LONG_TICKS <= 255) &&
                          (REPEAT_TICKS >= 1) && (REPEAT_TICKS <= 255) &&
                          (FIFO_DEPTH >= 2) &&
                          ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0);

  localparam logic [1:0] CODE_PRESS   = 2'd0;
  localparam logic [1:0] CODE_RELEASE = 2'd1;
  localparam logic [1:0] CODE_LONG    = 2'd2;
`ifdef BUTTON_AUTO_REPEAT_EN
  localparam logic [1:0] CODE_REPEAT  = 2'd3;
  localparam logic [7:0] REP_LIM      = 8'(REPEAT_TICKS);
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HELD,
    ST_LONG
  } btn_state_t;

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  logic [3:0] prev;
  logic [3:0] rise;
  logic [3:0] fall;

  btn_state_t state_q [4];
  btn_state_t state_d [4];
  logic [7:0] hold_q  [4];
  logic [7:0] hold_d  [4];
  logic [3:0] set_long;

  logic [3:0] pend_press;
  logic [3:0] pend_long;
  logic [3:0] pend_rel;
  logic [3:0] any_pend;
`ifdef BUTTON_AUTO_REPEAT_EN
  logic [3:0] set_rep;
  logic [3:0] pend_rep;
  logic [3:0] clr_rep;
`endif

  logic [1:0] rr_ptr;
  logic [1:0] scan_id;
  logic [1:0] grant_id;
  logic [1:0] grant_code;
  logic       grant_vld;
  logic [3:0] grant_sel;
  logic [3:0] clr_press;
  logic [3:0] clr_long;
  logic [3:0] clr_rel;
  logic       lost_now;

  logic [3:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          push;
  logic          pop;

  assign tick = CFG_OK && (div_cnt == DIV_LAST);
  assign rise = button_in & ~prev;
  assign fall = ~button_in & prev;

  // Free-running divider that produces one hold-timer tick every TICK_DIV clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Previous button levels for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= '0;
    end else begin
      prev <= button_in;
    end
  end

  // Per-button hold FSM state and hold counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= ST_IDLE;
        hold_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        hold_q[i]  <= hold_d[i];
      end
    end
  end

  // Hold FSM next state: a release always wins, otherwise ticks advance the timer.
  always_comb begin
    set_long = '0;
`ifdef BUTTON_AUTO_REPEAT_EN
    set_rep = '0;
`endif
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      hold_d[i]  = hold_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (rise[i]) begin
            state_d[i] = ST_HELD;
            hold_d[i]  = '0;
          end
        end
        ST_HELD: begin
          if (fall[i]) begin
            state_d[i] = ST_IDLE;
          end else if (tick) begin
            if (hold_q[i] + 8'd1 == LONG_LIM) begin
              set_long[i] = 1'b1;
              hold_d[i]   = '0;
              state_d[i]  = ST_LONG;
            end else begin
              hold_d[i] = hold_q[i] + 8'd1;
            end
          end
        end
        ST_LONG: begin
          if (fall[i]) begin
            state_d[i] = ST_IDLE;
          end else if (tick) begin
`ifdef BUTTON_AUTO_REPEAT_EN
            if (hold_q[i] + 8'd1 == REP_LIM) begin
              set_rep[i] = 1'b1;
              hold_d[i]  = '0;
            end else begin
              hold_d[i] = hold_q[i] + 8'd1;
            end
`else
            if (hold_q[i] != 8'hFF) begin
              hold_d[i] = hold_q[i] + 8'd1;
            end
`endif
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
        end
      endcase
    end
  end

  // Round-robin pick of the next button with pending work, then its highest-priority event.
  always_comb begin
    any_pend = pend_press | pend_long | pend_rel;
`ifdef BUTTON_AUTO_REPEAT_EN
    any_pend = any_pend | pend_rep;
`endif
    grant_id = rr_ptr;
    scan_id  = '0;
    for (int j = 3; j >= 0; j--) begin
      scan_id = rr_ptr + 2'(j);
      if (any_pend[scan_id]) begin
        grant_id = scan_id;
      end
    end
    grant_vld = (|any_pend) && !full;
    grant_sel = 4'b0001 << grant_id;
    if ((pend_press & grant_sel) != 4'b0000) begin
      grant_code = CODE_PRESS;
    end else if ((pend_long & grant_sel) != 4'b0000) begin
      grant_code = CODE_LONG;
`ifdef BUTTON_AUTO_REPEAT_EN
    end else if ((pend_rep & grant_sel) != 4'b0000) begin
      grant_code = CODE_REPEAT;
`endif
    end else begin
      grant_code = CODE_RELEASE;
    end
    clr_press = (grant_vld && grant_code == CODE_PRESS)   ? grant_sel : 4'b0000;
    clr_long  = (grant_vld && grant_code == CODE_LONG)    ? grant_sel : 4'b0000;
    clr_rel   = (grant_vld && grant_code == CODE_RELEASE) ? grant_sel : 4'b0000;
`ifdef BUTTON_AUTO_REPEAT_EN
    clr_rep   = (grant_vld && grant_code == CODE_REPEAT)  ? grant_sel : 4'b0000;
`endif
  end

  // A loss is a set landing on a bit that is already pending and not being granted now.
  always_comb begin
    lost_now = |((rise & pend_press & ~clr_press) |
                 (set_long & pend_long & ~clr_long) |
                 (fall & pend_rel & ~clr_rel));
`ifdef BUTTON_AUTO_REPEAT_EN
    lost_now = lost_now | (|(set_rep & pend_rep & ~clr_rep));
`endif
  end

  // Pending event bits, round-robin pointer and the sticky loss flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_press <= '0;
      pend_long  <= '0;
      pend_rel   <= '0;
`ifdef BUTTON_AUTO_REPEAT_EN
      pend_rep   <= '0;
`endif
      rr_ptr     <= '0;
      evt_lost   <= 1'b0;
    end else begin
      pend_press <= (pend_press & ~clr_press) | rise;
      pend_long  <= (pend_long & ~clr_long) | set_long;
      pend_rel   <= (pend_rel & ~clr_rel) | fall;
`ifdef BUTTON_AUTO_REPEAT_EN
      pend_rep   <= (pend_rep & ~clr_rep) | set_rep;
`endif
      if (grant_vld) begin
        rr_ptr <= grant_id + 2'd1;
      end
      if (lost_now) begin
        evt_lost <= 1'b1;
      end else if (evt_lost_clr) begin
        evt_lost <= 1'b0;
      end
    end
  end

  assign push      = grant_vld;
  assign pop       = evt_valid & evt_ready;
  assign full      = (count == FULL_CNT);
  assign evt_valid = (count != '0);
  assign evt_code  = fifo_mem[rd_ptr][3:2];
  assign evt_id    = fifo_mem[rd_ptr][1:0];

  // Event FIFO storage, pointers and occupancy; the head is always visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        fifo_mem[k] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {grant_code, grant_id};
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule
